// File: rtl/qeciphy_tx_scheduler_if.sv
// Bus bundle for the QECi PHY TX slot scheduler: the user AXI-Stream input
// and the scheduled word output toward the CRC/gearbox stage.
// The scheduler uses the master view. The surrounding logic uses the slave view.
interface qeciphy_tx_scheduler_if #(
  parameter int DATA_W = 64
);
  // User AXI-Stream side
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;

  // Scheduled output side
  logic [DATA_W-1:0] o_tx_data;
  logic [1:0]        o_tx_type;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_frame_start;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output o_tx_data,
    output o_tx_type,
    output o_tx_valid,
    input  i_tx_ready,
    output o_frame_start
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  o_tx_data,
    input  o_tx_type,
    input  o_tx_valid,
    output i_tx_ready,
    input  o_frame_start
  );
endinterface

// File: rtl/qeciphy_tx_scheduler.sv
// QECi PHY TX slot scheduler.
// Each output slot carries one of four word types:
//   - slot 0: frame alignment pattern (FAP)
//   - slot 1: link status word
//   - other slots: user data, or idle fill when no user data is available
// A single output register stage holds the word. A new word is loaded whenever
// that register is empty or the downstream stage accepts the current word.
// Optional feature: define QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN to send an extra
// STATUS word in the next data slot whenever the flags change.
module qeciphy_tx_scheduler #(
  parameter int          FAP_INTERVAL = 64,
  parameter int          DATA_W       = 64,
  parameter logic [63:0] FAP_WORD     = 64'hFA5A_C3C3_5AFA_3C3C,
  parameter logic [63:0] IDLE_WORD    = 64'h0707_0707_0707_0707
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   i_training,
  input  logic                   i_allow_user_tx,
  input  logic                   i_rx_rdy,
  input  logic                   i_pd_req,
  input  logic                   i_pd_ack,
  qeciphy_tx_scheduler_if.master tx_if
);

  localparam int SLOT_W = $clog2(FAP_INTERVAL);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FAP_INTERVAL - 1);
  localparam logic [SLOT_W-1:0] SLOT_FAP  = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_STAT = SLOT_W'(1);

  typedef enum logic [1:0] {
    TYPE_DATA   = 2'd0,
    TYPE_FAP    = 2'd1,
    TYPE_STATUS = 2'd2,
    TYPE_IDLE   = 2'd3
  } word_type_e;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DATA_W-1:0] data_q, data_d;
  word_type_e        type_q, type_d;
  logic              valid_q;
  logic              frame_start_q;

  logic              load;
  logic              user_ok;
  logic              data_slot;
  logic              pending_service;
  logic [2:0]        flags;
  logic [DATA_W-1:0] status_word;

  assign load        = ~valid_q | tx_if.i_tx_ready;
  assign user_ok     = i_allow_user_tx & ~i_training;
  assign data_slot   = (slot_q >= SLOT_W'(2));
  assign flags       = {i_pd_ack, i_pd_req, i_rx_rdy};
  assign status_word = DATA_W'(flags);

`ifdef QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN
  logic       status_pending_q;
  logic [2:0] last_flags_q;
  logic       status_load;

  // A pending status change is only serviced in a data slot, ahead of user data
  assign pending_service = data_slot & status_pending_q;
  assign status_load     = load & ((slot_q == SLOT_STAT) | pending_service);

  // Track the flags last sent and flag a change that no STATUS word has carried yet
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      status_pending_q <= 1'b0;
      last_flags_q     <= 3'b000;
    end else if (status_load) begin
      status_pending_q <= 1'b0;
      last_flags_q     <= flags;
    end else if (flags != last_flags_q) begin
      status_pending_q <= 1'b1;
    end
  end
`else
  assign pending_service = 1'b0;
`endif

  // User beats are accepted only into a data slot that is being loaded this cycle
  assign tx_if.s_axis_tready = ~axis_rst & load & data_slot & user_ok & ~pending_service;

  // Pick the word for the current slot and the following slot index
  always_comb begin
    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    data_d = IDLE_WORD[DATA_W-1:0];
    type_d = TYPE_IDLE;
    if (slot_q == SLOT_FAP) begin
      data_d = FAP_WORD[DATA_W-1:0];
      type_d = TYPE_FAP;
    end else if (slot_q == SLOT_STAT || pending_service) begin
      data_d = status_word;
      type_d = TYPE_STATUS;
    end else if (user_ok && tx_if.s_axis_tvalid) begin
      data_d = tx_if.s_axis_tdata;
      type_d = TYPE_DATA;
    end
  end

  // Output register. It advances the slot only on load and holds everything under backpressure.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      slot_q        <= '0;
      data_q        <= '0;
      type_q        <= TYPE_IDLE;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= load & (slot_q == SLOT_FAP);
      if (load) begin
        slot_q  <= slot_d;
        data_q  <= data_d;
        type_q  <= type_d;
        valid_q <= 1'b1;
      end
    end
  end

  assign tx_if.o_tx_data     = data_q;
  assign tx_if.o_tx_type     = type_q;
  assign tx_if.o_tx_valid    = valid_q;
  assign tx_if.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_qeciphy_tx_scheduler.sv
// Scoreboard bench for qeciphy_tx_scheduler.
// A slot-level reference model predicts each loaded word into a queue.
// A negedge monitor compares the DUT output against the queue head and pops
// the head when the word is handed downstream.
module tb_qeciphy_tx_scheduler;
  localparam int N  = 8;
  localparam int DW = 64;
  localparam logic [63:0] FAP  = 64'hFA5A_C3C3_5AFA_3C3C;
  localparam logic [63:0] IDLE = 64'h0707_0707_0707_0707;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  t;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic training, allow, rx_rdy, pd_req, pd_ack;

  qeciphy_tx_scheduler_if #(.DATA_W(DW)) bus();

  qeciphy_tx_scheduler #(
    .FAP_INTERVAL(N),
    .DATA_W(DW)
  ) dut (
    .axis_clk(clk),
    .axis_rst(rst),
    .i_training(training),
    .i_allow_user_tx(allow),
    .i_rx_rdy(rx_rdy),
    .i_pd_req(pd_req),
    .i_pd_ack(pd_ack),
    .tx_if(bus)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state, described at the slot level
  int    m_slot = 0;
  bit    m_valid = 0;
  bit    m_fs = 0;
  bit    m_taken = 0;
  bit    armed = 0;
  word_t exp_q[$];
`ifdef QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN
  bit         m_pending = 0;
  logic [2:0] m_last = 3'b000;
`endif
  longint seq = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit m_load();
    return !m_valid || bus.i_tx_ready;
  endfunction

  function automatic bit user_ok();
    return allow && !training;
  endfunction

  function automatic logic [2:0] cur_flags();
    return {pd_ack, pd_req, rx_rdy};
  endfunction

  function automatic bit pend_serv();
`ifdef QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN
    return m_pending && (m_slot >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic word_t pick_word();
    word_t w;
    if (m_slot == 0) begin
      w.d = FAP; w.t = 2'd1;
    end else if (m_slot == 1 || pend_serv()) begin
      w.d = {61'd0, cur_flags()}; w.t = 2'd2;
    end else if (user_ok() && bus.s_axis_tvalid) begin
      w.d = bus.s_axis_tdata; w.t = 2'd0;
    end else begin
      w.d = IDLE; w.t = 2'd3;
    end
    return w;
  endfunction

  // Reference model: advance one slot per predicted load
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        armed   = 1;
        m_valid = 0;
        m_slot  = 0;
        m_fs    = 0;
        m_taken = 0;
        exp_q.delete();
`ifdef QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN
        m_pending = 0;
        m_last    = 3'b000;
`endif
      end else begin
        bit ld;
        ld      = m_load();
        m_taken = ld && m_slot >= 2 && !pend_serv() && user_ok() && bus.s_axis_tvalid;
`ifdef QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN
        if (ld && (m_slot == 1 || pend_serv())) begin
          m_last    = cur_flags();
          m_pending = 0;
        end else if (cur_flags() != m_last) begin
          m_pending = 1;
        end
`endif
        m_fs = ld && (m_slot == 0);
        if (ld) begin
          exp_q.push_back(pick_word());
          m_valid = 1;
          m_slot  = (m_slot + 1) % N;
        end
      end
    end
  end

  // Monitor: compare away from the active edge and pop on each handoff
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("tready", 64'(bus.s_axis_tready),
            64'(!rst && m_load() && m_slot >= 2 && user_ok() && !pend_serv()));
        chk("tx_valid", 64'(bus.o_tx_valid), 64'(m_valid));
        chk("frame_start", 64'(bus.o_frame_start), 64'(m_fs));
        if (!m_valid) begin
          chk("reset_data", bus.o_tx_data, 64'd0);
          chk("reset_type", 64'(bus.o_tx_type), 64'd3);
        end else if (exp_q.size() == 0) begin
          chk("scoreboard_depth", 64'd0, 64'd1);
        end else begin
          chk("tx_data", bus.o_tx_data, exp_q[0].d);
          chk("tx_type", 64'(bus.o_tx_type), 64'(exp_q[0].t));
          if (bus.i_tx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus, applied just after the active edge
  task automatic step(input int rdy_pct, input int tv_pct, input bit rnd_flags, input bit rnd_train);
    @(posedge clk);
    #1;
    bus.i_tx_ready = ($urandom_range(99) < rdy_pct);
    if (!bus.s_axis_tvalid || m_taken) begin
      bus.s_axis_tvalid = ($urandom_range(99) < tv_pct);
      bus.s_axis_tdata  = {$urandom, 32'(seq)};
      seq++;
    end
    if (rnd_flags && $urandom_range(99) < 6) begin
      case ($urandom_range(2))
        0: rx_rdy = ~rx_rdy;
        1: pd_req = ~pd_req;
        default: pd_ack = ~pd_ack;
      endcase
    end
    if (rnd_train && $urandom_range(99) < 4) training = ~training;
  endtask

  task automatic run(input int n, input int rdy_pct, input int tv_pct, input bit rnd_flags, input bit rnd_train);
    for (int i = 0; i < n; i++) step(rdy_pct, tv_pct, rnd_flags, rnd_train);
  endtask

  // Advance with full throughput until the model's next slot is s, bounded
  task automatic wait_slot(input int s);
    int k;
    k = 0;
    while (m_slot != s && k < 4 * N) begin
      step(100, 0, 0, 0);
      k++;
    end
    if (m_slot != s) chk("wait_slot_timeout", 64'(m_slot), 64'(s));
  endtask

  initial begin
    rst = 1'b1;
    training = 1'b0; allow = 1'b0;
    rx_rdy = 1'b0; pd_req = 1'b0; pd_ack = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle frames: FAP, STATUS, then IDLE fill
    run(18, 100, 0, 0, 0);
    // Continuous user streaming
    allow = 1'b1;
    run(40, 100, 100, 0, 0);
    // Random backpressure during streaming
    run(200, 50, 80, 0, 0);
    // pd_req rising while slot 3 is loaded
    wait_slot(3);
    pd_req = 1'b1;
    run(2 * N, 100, 100, 0, 0);
    pd_req = 1'b0;
    run(2 * N, 100, 100, 0, 0);
    // Training blocks user data
    training = 1'b1;
    run(30, 100, 100, 0, 0);
    training = 1'b0;
    // Reset pulse at slot 5 under backpressure
    wait_slot(5);
    bus.i_tx_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.i_tx_ready = 1'b1;
    run(20, 100, 100, 0, 0);
    // Everything random
    run(400, 60, 70, 1, 1);
    allow = 1'b0;
    run(20, 100, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qeciphy_tx_scheduler.md
# qeciphy_tx_scheduler

- Slot scheduler for the QECi PHY transmit datapath.
- Each output word is one of four types, chosen per slot:
  - frame alignment pattern (FAP)
  - link status word carrying the rx_rdy / pd_req / pd_ack flags
  - user AXI-Stream data
  - idle fill
- Sits between the user TX AXI-Stream interface and the CRC/gearbox stage.
- Driven by the link controller's training, allow-user-tx and power-down handshake outputs.

## Interface

Parameters:
- FAP_INTERVAL, 64: slots per frame. Slot 0 carries the FAP and slot 1 the status word. Legal range 4..4096.
- DATA_W, 64: data word width. Must be ≥ 8.
- FAP_WORD, 64'hFA5A_C3C3_5AFA_3C3C: FAP payload, truncated to DATA_W LSBs.
- IDLE_WORD, 64'h0707_0707_0707_0707: idle payload, truncated to DATA_W LSBs.

Ports:
- axis_clk  in  1  sole clock
- axis_rst  in  1  reset, synchronous, active-high
- i_training  in  1  link training in progress; user data is blocked
- i_allow_user_tx  in  1  user data permitted in data slots
- i_rx_rdy  in  1  local receiver locked; sent in the status word
- i_pd_req  in  1  power-down request; sent in the status word
- i_pd_ack  in  1  power-down acknowledge; sent in the status word
- s_axis_tdata  in  DATA_W  user data
- s_axis_tvalid  in  1  user data valid
- s_axis_tready  out  1  user data accepted
- o_tx_data  out  DATA_W  scheduled word
- o_tx_type  out  2  word type: 0 DATA, 1 FAP, 2 STATUS, 3 IDLE
- o_tx_valid  out  1  output word valid
- i_tx_ready  in  1  downstream accepts the word
- o_frame_start  out  1  one-cycle pulse when a FAP word is loaded

## Operation

Output stage:
- Single output register stage.
- load = ~o_tx_valid | i_tx_ready.
- On every load, one word is computed from slot counter `slot` and registered, with o_tx_valid ← 1.

Slot counter:
- Counts 0..FAP_INTERVAL-1 and advances only on load.
- Wraps to 0 after FAP_INTERVAL-1.

Word selection on load:
- slot == 0: FAP. Payload FAP_WORD, type 1, o_frame_start pulses.
- slot == 1: STATUS. Payload {zeros, i_pd_ack, i_pd_req, i_rx_rdy}, with bit 0 = rx_rdy. Flags are sampled at load.
- slot ≥ 2 with status_pending set (macro builds only): STATUS. status_pending clears.
- slot ≥ 2 with user_ok & s_axis_tvalid: DATA. Payload s_axis_tdata, type 0.
  - user_ok = i_allow_user_tx & ~i_training.
- Otherwise: IDLE. Payload IDLE_WORD, type 3.

User handshake:
- s_axis_tready = load & (slot ≥ 2) & user_ok & ~status_pending.
- Combinational from registered state and i_tx_ready; it does not depend on s_axis_tvalid.
- A user beat transfers exactly when s_axis_tvalid & s_axis_tready. That beat is the DATA word loaded that cycle.
- No user word is ever dropped or duplicated.

Gating and boundary cases:
- Deasserting i_allow_user_tx or asserting i_training takes effect the same cycle. tready drops and the slot fills with IDLE.
- A word already registered is still delivered.
- Backpressure (o_tx_valid & ~i_tx_ready) holds o_tx_data, o_tx_type, o_tx_valid and slot unchanged. s_axis_tready = 0.

## Timing

- Latency from user beat accept to o_tx_data: 1 cycle.
- Throughput: 1 word/cycle when i_tx_ready is held high. User efficiency is (FAP_INTERVAL-2)/FAP_INTERVAL.

Reset values (axis_rst sampled high at an edge):
- o_tx_valid = 0
- o_tx_data = 0
- o_tx_type = 3
- o_frame_start = 0
- slot = 0
- status_pending = 0
- last_flags = 0

After reset:
- Reset may assert mid-frame or mid-backpressure; the registered word is discarded.
- The first load after reset release emits FAP.
- s_axis_tready = 0 while axis_rst is high.

o_frame_start is high only in the cycle following the FAP load.

## Configuration

Macro: QECIPHY_TXSCHED_STATUS_ON_CHANGE_EN.

Defined:
- last_flags holds the flags of the most recent STATUS word.
- When {i_pd_ack, i_pd_req, i_rx_rdy} ≠ last_flags and no STATUS is being loaded this cycle, status_pending ← 1.
- The next load in a slot ≥ 2 emits STATUS with the then-current flags and clears status_pending. It has priority over user data.
- A change coinciding with a slot-1 or pending STATUS load is carried by that word; pending is not set.
- status_pending is not serviced in slot 0; it waits for the next slot ≥ 2.
- Worst-case flag-change latency: 3 loads.

Undefined:
- STATUS is sent only in slot 1.
- status_pending and last_flags are absent.
- Flag-change latency: up to FAP_INTERVAL loads.

## Test plan

- Reset, then i_tx_ready = 1 and s_axis_tvalid = 0 with FAP_INTERVAL = 8 → type sequence 1,2,3,3,3,3,3,3,1. o_frame_start pulses every 8 cycles.
- i_allow_user_tx = 1 with user words 0x1..0x10 streamed continuously (FAP_INTERVAL = 8) → DATA payloads in order with no gaps except slots 0/1. Each word appears 1 cycle after its accept.
- i_tx_ready toggled pseudo-randomly (50%) during user streaming → output holds stable while stalled. Every user word is delivered exactly once, in order; slot count matches the number of accepted loads.
- i_pd_req rises in slot 3 (macro on) → STATUS with payload 0x2 (bit1 = pd_req) in slot 4. s_axis_tready = 0 that cycle. The same stimulus with macro off → STATUS with pd_req set appears only at the next slot 1.
- i_training = 1 with s_axis_tvalid = 1 → s_axis_tready stays 0. Only FAP/STATUS/IDLE are emitted.
- axis_rst pulsed for 1 cycle at slot 5 under backpressure → o_tx_valid = 0 and o_tx_type = 3 the next cycle. The first load afterwards is FAP with o_frame_start = 1.
